i2c_sensor_poller: RTL and testbench

//  Periodic burst-read sequencer sitting directly upstream of the single-byte I2C register-read controller.

---
 rtl/i2c_pkg.sv | 7 +
 rtl/i2c_sensor_poller_poll_timer.sv | 16 +
 rtl/i2c_sensor_poller.sv | 90 +++++++++
 tb/tb_i2c_sensor_poller.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared poller state type and MPU6050 register map
package i2c_pkg;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, GAP, PUBLISH} poller_state_t;
    localparam logic [6:0] MPU6050_ADDR = 7'h68;
    localparam logic [7:0] ACCEL_XOUT_H = 8'h3B;
    localparam logic [7:0] GYRO_XOUT_H  = 8'h43;
endpackage

// File: rtl/i2c_sensor_poller_poll_timer.sv
// poll_timer: free-running 0..POLL_DIV-1 counter, tick on terminal count
// Ports: clock, reset (async, active-high), tick (high while count==POLL_DIV-1)
module poll_timer #(
    parameter int POLL_DIV = 100000
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);
    localparam int CW = $clog2(POLL_DIV);
    logic [CW-1:0] count;
    assign tick = count == CW'(POLL_DIV - 1);
    always_ff @(posedge clock or posedge reset)
        if (reset) count <= '0;
        else count <= tick ? '0 : count + 1'b1;
endmodule

// File: rtl/i2c_sensor_poller.sv
// i2c_sensor_poller: periodic burst register reader assembling big-endian 16-bit words
// Ports: clock, reset (async, active-high), enable (permits launches);
//        i2c_addr/i2c_start to the byte-read controller, i2c_data/i2c_done back from it;
//        sample_words/sample_valid published sample, busy, timeout_err pulse, overrun (sticky)
module i2c_sensor_poller
    import i2c_pkg::*;
#(
    parameter logic [7:0] BASE_REG       = ACCEL_XOUT_H,
    parameter int         NUM_WORDS      = 3,
    parameter int         POLL_DIV       = 100000,
    parameter int         TIMEOUT_CYCLES = 20000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    output logic [7:0]             i2c_addr,
    output logic                   i2c_start,
    input  logic [7:0]             i2c_data,
    input  logic                   i2c_done,
    output logic [16*NUM_WORDS-1:0] sample_words,
    output logic                   sample_valid,
    output logic                   busy,
    output logic                   timeout_err,
    output logic                   overrun
);
    localparam int NB = 2 * NUM_WORDS;
    localparam int IW = $clog2(NB);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    poller_state_t state, state_n;
    logic [IW-1:0] index, slot;
    logic [TW-1:0] wait_count;
    logic [16*NUM_WORDS-1:0] buffer, assembled;
    logic tick, last_byte, timed_out;
    poll_timer #(.POLL_DIV(POLL_DIV)) u_timer (.clock(clock), .reset(reset), .tick(tick));
    assign last_byte = index == IW'(NB - 1);
    assign timed_out = wait_count == TW'(TIMEOUT_CYCLES - 1);
    assign busy      = state != IDLE;
    assign i2c_addr  = BASE_REG + 8'(index);
    // Buffer is kept in output layout: even bytes are word high halves, so byte j sits at slot j^1.
    assign slot = index ^ IW'(1);
    // The final byte is merged straight from i2c_data so the sample is ready in the PUBLISH cycle.
    always_comb begin
        assembled = buffer;
        assembled[16*(NUM_WORDS-1) +: 8] = i2c_data;
    end
    always_ff @(posedge clock or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_n;
    always_comb begin
        state_n      = state;
        i2c_start    = 1'b0;
        sample_valid = 1'b0;
        timeout_err  = 1'b0;
        case (state)
            IDLE:      state_n = (tick && enable) ? ISSUE : IDLE;
            ISSUE: begin
                i2c_start = 1'b1;
                state_n   = WAIT_DONE;
            end
            WAIT_DONE: begin
                timeout_err = !i2c_done && timed_out;
                state_n     = i2c_done ? (last_byte ? PUBLISH : GAP) : (timed_out ? IDLE : WAIT_DONE);
            end
            GAP:       state_n = ISSUE;
            PUBLISH: begin
                sample_valid = 1'b1;
                state_n      = IDLE;
            end
            default:   state_n = IDLE;
        endcase
    end
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            index        <= '0;
            wait_count   <= '0;
            sample_words <= '0;
            overrun      <= 1'b0;
        end else begin
            if (tick && busy) overrun <= 1'b1;
            if (state == IDLE) index <= '0;
            if (state == ISSUE) wait_count <= '0;
            else if (state == WAIT_DONE) wait_count <= wait_count + 1'b1;
            if (state == WAIT_DONE && i2c_done) begin
                index <= index + 1'b1;
                if (last_byte) sample_words <= assembled;
            end
        end
    always_ff @(posedge clock)
        if (state == WAIT_DONE && i2c_done) buffer[8*slot +: 8] <= i2c_data;
endmodule

// File: tb/tb_i2c_sensor_poller.sv
// tb_i2c_sensor_poller: directed bench with controller models for three poller configurations
module tb_i2c_sensor_poller;
    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset_a, reset_bc, enable_a, enable_b;
    logic [7:0] addr_a, addr_b, addr_c;
    logic [7:0] data_a = 8'h00, data_b = 8'h5A, data_c = 8'h00;
    logic start_a, start_b, start_c;
    logic done_a = 1'b0, done_b = 1'b0, done_c = 1'b0;
    logic [47:0] words_a, words_b;
    logic [31:0] words_c;
    logic valid_a, valid_b, valid_c, busy_a, busy_b, busy_c;
    logic terr_a, terr_b, terr_c, ovr_a, ovr_b, ovr_c;
    i2c_sensor_poller #(.BASE_REG(8'h3B), .NUM_WORDS(3), .POLL_DIV(50), .TIMEOUT_CYCLES(200)) dut_a (
        .clock(clock), .reset(reset_a), .enable(enable_a), .i2c_addr(addr_a), .i2c_start(start_a),
        .i2c_data(data_a), .i2c_done(done_a), .sample_words(words_a), .sample_valid(valid_a),
        .busy(busy_a), .timeout_err(terr_a), .overrun(ovr_a));
    i2c_sensor_poller #(.BASE_REG(8'h3B), .NUM_WORDS(3), .POLL_DIV(50), .TIMEOUT_CYCLES(10)) dut_b (
        .clock(clock), .reset(reset_bc), .enable(enable_b), .i2c_addr(addr_b), .i2c_start(start_b),
        .i2c_data(data_b), .i2c_done(done_b), .sample_words(words_b), .sample_valid(valid_b),
        .busy(busy_b), .timeout_err(terr_b), .overrun(ovr_b));
    i2c_sensor_poller #(.BASE_REG(8'hFE), .NUM_WORDS(2), .POLL_DIV(50), .TIMEOUT_CYCLES(200)) dut_c (
        .clock(clock), .reset(reset_bc), .enable(1'b1), .i2c_addr(addr_c), .i2c_start(start_c),
        .i2c_data(data_c), .i2c_done(done_c), .sample_words(words_c), .sample_valid(valid_c),
        .busy(busy_c), .timeout_err(terr_c), .overrun(ovr_c));
    // controller models: done a_delay (or 3) cycles after start, data = addr ^ FF
    int a_delay = 3, a_cnt = 0, c_cnt = 0;
    logic a_pend = 1'b0, c_pend = 1'b0;
    logic [7:0] a_req = 8'h00, c_req = 8'h00;
    always @(posedge clock) begin
        done_a <= 1'b0;
        if (start_a) begin
            a_pend <= 1'b1;
            a_cnt  <= 1;
            a_req  <= addr_a;
        end else if (a_pend) begin
            if (a_cnt == a_delay - 1) begin
                done_a <= 1'b1;
                data_a <= a_req ^ 8'hFF;
                a_pend <= 1'b0;
            end else a_cnt <= a_cnt + 1;
        end
    end
    always @(posedge clock) begin
        done_c <= 1'b0;
        if (start_c) begin
            c_pend <= 1'b1;
            c_cnt  <= 1;
            c_req  <= addr_c;
        end else if (c_pend) begin
            if (c_cnt == 2) begin
                done_c <= 1'b1;
                data_c <= c_req ^ 8'hFF;
                c_pend <= 1'b0;
            end else c_cnt <= c_cnt + 1;
        end
    end
    // monitors
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;
    logic [7:0] sa_addr [64];
    int sa_cyc [64];
    int n_sa = 0, n_va = 0, va_cyc = 0;
    logic [47:0] va_words = '0;
    logic va_busy = 1'b0;
    always @(negedge clock) begin
        if (start_a && n_sa < 64) begin
            sa_addr[n_sa] <= addr_a;
            sa_cyc[n_sa]  <= cyc;
            n_sa          <= n_sa + 1;
        end
        if (valid_a) begin
            n_va     <= n_va + 1;
            va_cyc   <= cyc;
            va_words <= words_a;
            va_busy  <= busy_a;
        end
    end
    logic [7:0] sb_addr [2];
    int sb_cyc [2];
    int n_sb = 0, n_tb = 0, tb_cyc = 0, n_vb = 0;
    always @(negedge clock) begin
        if (start_b) begin
            if (n_sb < 2) begin
                sb_addr[n_sb] <= addr_b;
                sb_cyc[n_sb]  <= cyc;
            end
            n_sb <= n_sb + 1;
        end
        if (terr_b) begin
            if (n_tb == 0) tb_cyc <= cyc;
            n_tb <= n_tb + 1;
        end
        if (valid_b) n_vb <= n_vb + 1;
    end
    logic [7:0] sc_addr [4];
    int n_sc = 0, n_vc = 0;
    logic [31:0] vc_words = '0;
    always @(negedge clock) begin
        if (start_c) begin
            if (n_sc < 4) sc_addr[n_sc] <= addr_c;
            n_sc <= n_sc + 1;
        end
        if (valid_c) begin
            if (n_vc == 0) vc_words <= words_c;
            n_vc <= n_vc + 1;
        end
    end
    int checks = 0, failures = 0, rel = 0, n0 = 0;
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clock);
        #2;
    endtask
    task automatic wait_sa(input int n, input int budget);
        int k = 0;
        while (n_sa < n && k < budget) begin
            step();
            k++;
        end
        check("wait_start", 64'(n_sa >= n), 64'd1);
    endtask
    task automatic wait_va(input int n, input int budget);
        int k = 0;
        while (n_va < n && k < budget) begin
            step();
            k++;
        end
        check("wait_valid", 64'(n_va >= n), 64'd1);
    endtask
    initial begin
        logic gaps_ok;
        reset_a = 1'b1; reset_bc = 1'b1; enable_a = 1'b1; enable_b = 1'b1;
        repeat (3) step();
        check("rst_start", 64'(start_a), 64'd0);
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_valid", 64'(valid_a), 64'd0);
        check("rst_words", 64'(words_a), 64'd0);
        check("rst_addr", 64'(addr_a), 64'h3B);
        check("rst_terr", 64'(terr_a), 64'd0);
        check("rst_ovr", 64'(ovr_a), 64'd0);
        check("rst_addr_c", 64'(addr_c), 64'hFE);
        reset_a = 1'b0; reset_bc = 1'b0; rel = cyc;
        wait_va(1, 200);
        check("burst1_starts", 64'(n_sa), 64'd6);
        check("first_start_lat", 64'(sa_cyc[0]), 64'(rel + 50));
        for (int i = 0; i < 6; i++) check("burst1_addr", 64'(sa_addr[i]), 64'(8'h3B + i));
        gaps_ok = 1'b1;
        for (int i = 0; i < 5; i++) if (sa_cyc[i+1] - sa_cyc[i] != 5) gaps_ok = 1'b0;
        check("burst1_gap", 64'(gaps_ok), 64'd1);
        check("valid_lat", 64'(va_cyc), 64'(sa_cyc[5] + 4));
        check("burst1_words", 64'(va_words), 64'hC0BF_C2C1_C4C3);
        check("publish_busy", 64'(va_busy), 64'd1);
        check("idle_busy", 64'(busy_a), 64'd0);
        check("hold_words", 64'(words_a), 64'hC0BF_C2C1_C4C3);
        wait_sa(8, 200);
        enable_a = 1'b0;
        wait_va(2, 200);
        check("en_drop_starts", 64'(n_sa), 64'd12);
        check("en_drop_words", 64'(va_words), 64'hC0BF_C2C1_C4C3);
        repeat (120) step();
        check("en_off_no_start", 64'(n_sa), 64'd12);
        enable_a = 1'b1;
        wait_sa(16, 200);
        check("pre_rst_busy", 64'(busy_a), 64'd1);
        reset_a = 1'b1;
        #1;
        check("midrst_start", 64'(start_a), 64'd0);
        check("midrst_busy", 64'(busy_a), 64'd0);
        check("midrst_words", 64'(words_a), 64'd0);
        check("midrst_addr", 64'(addr_a), 64'h3B);
        repeat (5) step();
        reset_a = 1'b0; rel = cyc;
        check("midrst_no_valid", 64'(n_va), 64'd2);
        wait_va(3, 200);
        check("postrst_addr", 64'(sa_addr[16]), 64'h3B);
        check("postrst_lat", 64'(sa_cyc[16]), 64'(rel + 50));
        check("postrst_words", 64'(va_words), 64'hC0BF_C2C1_C4C3);
        a_delay = 80;
        n0 = n_sa;
        wait_sa(n0 + 1, 100);
        check("ovr_before", 64'(ovr_a), 64'd0);
        enable_a = 1'b0;
        repeat (60) step();
        check("ovr_set", 64'(ovr_a), 64'd1);
        wait_va(4, 700);
        check("ovr_burst_words", 64'(va_words), 64'hC0BF_C2C1_C4C3);
        check("ovr_burst_starts", 64'(n_sa), 64'(n0 + 6));
        check("ovr_sticky", 64'(ovr_a), 64'd1);
        check("to_first_addr", 64'(sb_addr[0]), 64'h3B);
        check("to_pulse_lat", 64'(tb_cyc), 64'(sb_cyc[0] + 10));
        check("to_no_valid", 64'(n_vb), 64'd0);
        check("to_relaunch_addr", 64'(sb_addr[1]), 64'h3B);
        check("to_relaunch_lat", 64'(sb_cyc[1]), 64'(sb_cyc[0] + 50));
        check("to_words_kept", 64'(words_b), 64'd0);
        check("to_no_ovr", 64'(ovr_b), 64'd0);
        for (int i = 0; i < 4; i++) check("wrap_addr", 64'(sc_addr[i]), 64'(8'(8'hFE + i)));
        check("wrap_valid", 64'(n_vc >= 1), 64'd1);
        check("wrap_words", 64'(vc_words), 64'hFFFE_0100);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
